// File: rtl/serial_detect_arbiter_pkg.sv
// rtl/serial_detect_arbiter_pkg.sv - shared scheduler state and detector encodings
//   no ports; imported by run_detector and serial_detect_arbiter
package serial_detect_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GRANT  = 2'd1,
      RUN    = 2'd2,
      REPORT = 2'd3
   } sched_state_t;

   // One-hot detector states: A = no run, B = one '1' seen, C = two or more '1's
   localparam logic [2:0] DET_A = 3'b001;
   localparam logic [2:0] DET_B = 3'b010;
   localparam logic [2:0] DET_C = 3'b100;

endpackage

// File: rtl/serial_detect_arbiter_run_detector.sv
// rtl/serial_detect_arbiter_run_detector.sv - one-hot Moore run-of-ones detector
//   clk, rst_n : clock, asynchronous active-low reset
//   clr        : force state A on the next edge
//   en         : advance the detector with w this cycle
//   w          : serial input bit
//   match      : high while the detector is in state C
//   pre_hit    : this edge moves into or stays in C (en & w & (B|C))
module run_detector
   import serial_detect_arbiter_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   input  logic w,
   output logic match,
   output logic pre_hit
);

   logic [2:0] det;
   logic       det_ok;
   logic       in_bc;

   assign det_ok  = (det == DET_A) || (det == DET_B) || (det == DET_C);
   assign in_bc   = (det == DET_B) || (det == DET_C);
   assign match   = (det == DET_C);
   assign pre_hit = en & w & in_bc;

   // A corrupted (non-one-hot) register recovers to A regardless of en
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det <= DET_A;
      end else if (clr || !det_ok) begin
         det <= DET_A;
      end else if (en) begin
         if (!w)
            det <= DET_A;
         else if (det == DET_A)
            det <= DET_B;
         else
            det <= DET_C;
      end
   end

endmodule

// File: rtl/serial_detect_arbiter.sv
// rtl/serial_detect_arbiter.sv - round-robin sharing of one run detector among requesters
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester level request
//   din        : per-requester serial bit, only the granted one is used
//   gnt        : one-hot grant (zero outside GRANT/RUN)
//   busy       : high in GRANT, RUN and REPORT
//   match      : detector in state C
//   done       : one-cycle pulse in REPORT with done_id and hit_cnt valid
module serial_detect_arbiter
   import serial_detect_arbiter_pkg::*;
#(
   parameter int N_REQ = 4,
   parameter int BURST = 8,
   parameter int ID_W  = $clog2(N_REQ),
   parameter int CNT_W = $clog2(BURST + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic [N_REQ-1:0] din,
   output logic [N_REQ-1:0] gnt,
   output logic             busy,
   output logic             match,
   output logic             done,
   output logic [ID_W-1:0]  done_id,
   output logic [CNT_W-1:0] hit_cnt
);

   sched_state_t     state;
   logic [ID_W-1:0]  cur;
   logic [ID_W-1:0]  last;
   logic [CNT_W-1:0] bit_cnt;
   logic [ID_W-1:0]  pick;
   logic [ID_W-1:0]  idx;
   logic             pick_vld;
   logic             pre_hit;

   // Search last+1, last+2, ... (mod N_REQ); the first set request wins
   always_comb begin
      pick     = '0;
      pick_vld = 1'b0;
      idx      = '0;
      for (int i = 1; i <= N_REQ; i++) begin
         idx = ID_W'((int'(last) + i) % N_REQ);
         if (!pick_vld && req[idx]) begin
            pick     = idx;
            pick_vld = 1'b1;
         end
      end
   end

   run_detector u_det (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     ((state == GRANT) || (state == REPORT)),
      .en      (state == RUN),
      .w       (din[cur]),
      .match   (match),
      .pre_hit (pre_hit)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         cur     <= '0;
         last    <= ID_W'(N_REQ - 1);
         gnt     <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         done_id <= '0;
         hit_cnt <= '0;
         bit_cnt <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_vld) begin
                  cur   <= pick;
                  gnt   <= {{(N_REQ-1){1'b0}}, 1'b1} << pick;
                  busy  <= 1'b1;
                  state <= GRANT;
               end
            end
            GRANT: begin
               bit_cnt <= '0;
               hit_cnt <= '0;
               state   <= RUN;
            end
            RUN: begin
               hit_cnt <= hit_cnt + CNT_W'(pre_hit);
               // done/gnt change on the last sample edge so they line up with REPORT
               if (bit_cnt == CNT_W'(BURST - 1)) begin
                  gnt     <= '0;
                  done    <= 1'b1;
                  done_id <= cur;
                  state   <= REPORT;
               end else begin
                  bit_cnt <= bit_cnt + CNT_W'(1);
               end
            end
            REPORT: begin
               last  <= cur;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_detect_arbiter.sv
// tb/tb_serial_detect_arbiter.sv - self-checking bench for serial_detect_arbiter
module tb_serial_detect_arbiter;

   localparam int N_REQ = 4;
   localparam int BURST = 8;
   localparam int ID_W  = 2;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N_REQ-1:0] req = '0;
   logic [N_REQ-1:0] din = '0;
   logic [N_REQ-1:0] gnt;
   logic             busy;
   logic             match;
   logic             done;
   logic [ID_W-1:0]  done_id;
   logic [CNT_W-1:0] hit_cnt;

   int n_cmp = 0;
   int n_bad = 0;
   int model_last = N_REQ - 1;

   always #5 clk = ~clk;

   serial_detect_arbiter #(.N_REQ(N_REQ), .BURST(BURST)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .din     (din),
      .gnt     (gnt),
      .busy    (busy),
      .match   (match),
      .done    (done),
      .done_id (done_id),
      .hit_cnt (hit_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic int rr_next(input int lst, input logic [N_REQ-1:0] r);
      for (int i = 1; i <= N_REQ; i++)
         if (r[(lst + i) % N_REQ]) return (lst + i) % N_REQ;
      return -1;
   endfunction

   // Called at a negedge while the DUT is idle.
   // mode: 0 random, 1 all ones, 2 all zeros, 3 alternating 1010.., 4 vec (LSB first)
   task automatic burst(input logic [N_REQ-1:0] r, input int mode, input logic [7:0] vec,
                        input int drop_at, input int rst_at);
      int         id;
      int         hits;
      logic [7:0] bits;
      logic       exp_m;
      id = rr_next(model_last, r);
      for (int k = 0; k < BURST; k++) begin
         case (mode)
            0:       bits[k] = 1'($urandom_range(0, 1));
            1:       bits[k] = 1'b1;
            2:       bits[k] = 1'b0;
            3:       bits[k] = (k % 2 == 0);
            default: bits[k] = vec[k];
         endcase
      end
      hits = 0;
      req = r;
      @(posedge clk); @(negedge clk);
      chk("gnt_grant", gnt, 32'(1) << id);
      chk("busy_grant", busy, 1);
      chk("match_grant", match, 0);
      chk("done_grant", done, 0);
      @(posedge clk); @(negedge clk);
      chk("gnt_run1", gnt, 32'(1) << id);
      chk("match_run1", match, 0);
      for (int k = 0; k < BURST; k++) begin
         din = N_REQ'($urandom);
         din[id] = bits[k];
         req = N_REQ'($urandom);
         req[id] = !(drop_at >= 0 && k >= drop_at);
         if (k == rst_at) begin
            rst_n = 1'b0;
            #1;
            chk("rst_gnt", gnt, 0);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_match", match, 0);
            chk("rst_hit_cnt", hit_cnt, 0);
            @(posedge clk); @(negedge clk);
            rst_n = 1'b1;
            req = '0;
            model_last = N_REQ - 1;
            return;
         end
         @(posedge clk); @(negedge clk);
         exp_m = (k > 0) && bits[k] && bits[k-1];
         if (exp_m) hits++;
         chk("match_run", match, exp_m);
         if (k < BURST - 1) begin
            chk("gnt_run", gnt, 32'(1) << id);
            chk("done_run", done, 0);
         end else begin
            chk("done_report", done, 1);
            chk("done_id", done_id, id);
            chk("hit_cnt", hit_cnt, hits);
            chk("gnt_report", gnt, 0);
            chk("busy_report", busy, 1);
         end
      end
      req = '0;
      model_last = id;
      @(posedge clk); @(negedge clk);
      chk("done_idle", done, 0);
      chk("gnt_idle", gnt, 0);
      chk("busy_idle", busy, 0);
      chk("match_idle", match, 0);
   endtask

   initial begin
      logic [N_REQ-1:0] r;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_gnt", gnt, 0);
      chk("reset_busy", busy, 0);
      chk("reset_match", match, 0);
      chk("reset_done", done, 0);
      chk("reset_done_id", done_id, 0);
      chk("reset_hit_cnt", hit_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); @(negedge clk);
      chk("idle_no_req", gnt, 0);

      // 1,1,1,0,1,1,0,0 on requester 0
      burst(4'b0001, 4, 8'b0011_0111, -1, -1);
      // all requesting: rotation
      for (int b = 0; b < 5; b++) burst(4'b1111, 0, 8'h00, -1, -1);
      burst(4'b0100, 1, 8'h00, -1, -1);
      burst(4'b0100, 2, 8'h00, -1, -1);
      burst(4'b1000, 3, 8'h00, -1, -1);
      // ends with 1, next starts with 1
      burst(4'b0100, 4, 8'b1000_0000, -1, -1);
      burst(4'b0100, 4, 8'b0000_0001, -1, -1);
      // request dropped at RUN cycle 3
      burst(4'b0010, 0, 8'h00, 2, -1);
      for (int b = 0; b < 10; b++) begin
         do r = N_REQ'($urandom); while (r == '0);
         burst(r, 0, 8'h00, -1, -1);
      end
      // reset mid-burst, then requester 0 favoured
      burst(4'b0001, 0, 8'h00, -1, -1);
      burst(4'b0010, 0, 8'h00, -1, 3);
      burst(4'b1111, 0, 8'h00, -1, -1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
